// File: rtl/msk_ciphertext_out_serializer.sv
// Captures one shared 128-bit ciphertext from the masked core and streams it
// as 32-bit words, share by share, over a valid/ready interface.
// Each output bit selects exactly one held bit, so shares never recombine.
module msk_ciphertext_out_serializer #(
    parameter int unsigned d  = 2,
    parameter int unsigned SW = (d > 1) ? $clog2(d) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [128*d-1:0] sh_data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [SW-1:0]    out_share,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned NWORDS = 4 * d;
    localparam int unsigned CW     = $clog2(NWORDS);
    localparam int unsigned NSLOT  = 1 << CW;
    localparam int unsigned LAST   = NWORDS - 1;
    localparam int unsigned BW     = 128 * d;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [BW-1:0]              buf_q;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       load;
    logic                       last_c;
    logic [NSLOT-1:0][31:0]     word_tbl;

    // De-interleave: word k = share k/4, word k%4 of that share; unused slots are zero
    for (genvar k = 0; k < NSLOT; k++) begin : g_word
        if (k < NWORDS) begin : g_map
            for (genvar b = 0; b < 32; b++) begin : g_bit
                assign word_tbl[k][b] = buf_q[(32*(k%4)+b)*d + k/4];
            end
        end else begin : g_pad
            assign word_tbl[k] = '0;
        end
    end

    // Output decode from the held block and word counter
    assign last_c    = (state_q == SEND) && (cnt_q == CW'(LAST));
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = last_c;
    assign out_share = SW'(cnt_q >> 2);
    assign out_data  = word_tbl[cnt_q];
    // Accept while idle, or in the same cycle the final word leaves (no bubble)
    assign in_ready  = rst_n && ((state_q == IDLE) || (last_c && out_ready));

    // Next-state and counter control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!last_c) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (in_valid) begin
                        load  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and block buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                buf_q <= sh_data_in;
            end
        end
    end

endmodule

// File: tb/tb_msk_ciphertext_out_serializer.sv
// Self-checking bench: d=2 and d=3 instances against a queue-based word model.
module tb_msk_ciphertext_out_serializer;

    localparam logic [127:0] CT   = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;
    localparam logic [127:0] ONES = '1;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  share;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // d=2 instance
    logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
    logic [255:0] sh2 = '0;
    logic [31:0]  out_data2;
    logic [0:0]   out_share2;
    logic         out_last2, busy2;

    // d=3 instance
    logic         in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0;
    logic [383:0] sh3 = '0;
    logic [31:0]  out_data3;
    logic [1:0]   out_share3;
    logic         out_last3, busy3;

    msk_ciphertext_out_serializer #(.d(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .sh_data_in(sh2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_share(out_share2), .out_last(out_last2), .busy(busy2)
    );

    msk_ciphertext_out_serializer #(.d(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .sh_data_in(sh3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_share(out_share3), .out_last(out_last3), .busy(busy3)
    );

    int          tests = 0;
    int          fails = 0;
    int          dsel = 0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cap_flag = 1'b0;
    logic [127:0] shr [3];
    word_t       q[$];
    logic [31:0] got[$];
    logic [31:0] plain [8] = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470,
                               32'h0, 32'h0, 32'h0, 32'h0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare against the model, advance the model
    task automatic tick();
        logic [383:0] b;
        logic         exp_ir, ov, ir, bz, ol;
        logic [31:0]  od;
        logic [1:0]   os;
        int           dd;
        dd = (dsel == 0) ? 2 : 3;
        b  = '0;
        for (int i = 0; i < 128; i++)
            for (int s = 0; s < dd; s++)
                b[i*dd+s] = shr[s][i];
        sh2 = b[255:0];
        sh3 = b;
        in_valid2  = (dsel == 0) && in_valid;
        out_ready2 = (dsel == 0) && out_ready;
        in_valid3  = (dsel == 1) && in_valid;
        out_ready3 = (dsel == 1) && out_ready;
        #1;
        if (dsel == 0) begin
            ov = out_valid2; ir = in_ready2; bz = busy2; ol = out_last2;
            od = out_data2;  os = {1'b0, out_share2};
        end else begin
            ov = out_valid3; ir = in_ready3; bz = busy3; ol = out_last3;
            od = out_data3;  os = out_share3;
        end
        exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
        chk("out_valid", 64'(ov), 64'(q.size() != 0));
        chk("in_ready", 64'(ir), 64'(exp_ir));
        chk("busy", 64'(bz), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 64'(od), 64'(q[0].data));
            chk("out_share", 64'(os), 64'(q[0].share));
            chk("out_last", 64'(ol), 64'(q[0].last));
        end
        cap_flag = in_valid && exp_ir;
        if (q.size() != 0 && out_ready) begin
            got.push_back(od);
            void'(q.pop_front());
        end
        if (cap_flag)
            for (int s = 0; s < dd; s++)
                for (int w = 0; w < 4; w++)
                    q.push_back(word_t'{shr[s][32*w +: 32], 2'(s), (s == dd-1) && (w == 3)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        #1;
        chk("rst_in_ready2_low", 64'(in_ready2), 64'(0));
        chk("rst_in_ready3_low", 64'(in_ready3), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        #1;
        chk("rst_out_valid", 64'(out_valid2), 64'(0));
        chk("rst_busy", 64'(busy2), 64'(0));
        chk("rst_out_data", 64'(out_data2), 64'(0));
        chk("rst_out_share", 64'(out_share2), 64'(0));
        chk("rst_out_last", 64'(out_last2), 64'(0));
        chk("rst_in_ready2_high", 64'(in_ready2), 64'(1));
        chk("rst_out_valid3", 64'(out_valid3), 64'(0));
        chk("rst_in_ready3_high", 64'(in_ready3), 64'(1));
    endtask

    task automatic rand_shares();
        for (int s = 0; s < 3; s++) shr[s] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int caps;
        int cap2_c;
        shr[0] = '0; shr[1] = '0; shr[2] = '0;
        do_reset();

        // Plain ciphertext in share 0, share 1 zero
        dsel = 0; shr[0] = CT; shr[1] = '0; got.delete();
        in_valid = 1'b1; out_ready = 1'b1; tick();
        in_valid = 1'b0; repeat (9) tick();
        chk("plain_count", 64'(got.size()), 64'(8));
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("plain_word%0d", k), 64'(got[k]), 64'(plain[k]));

        // Masked: share words XOR back to the plain words
        shr[1] = ONES; shr[0] = CT ^ ONES; got.delete();
        in_valid = 1'b1; tick();
        in_valid = 1'b0; repeat (9) tick();
        chk("masked_count", 64'(got.size()), 64'(8));
        if (got.size() == 8)
            for (int k = 0; k < 4; k++)
                chk($sformatf("masked_xor%0d", k), 64'(got[k] ^ got[k+4]), 64'(plain[k]));

        // Back-pressure while word 2 is presented
        shr[0] = CT; shr[1] = '0; got.delete();
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick(); tick();
        out_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_hold_data", 64'(out_data2), 64'(32'h80b7cdd8));
            chk("bp_in_ready", 64'(in_ready2), 64'(0));
        end
        out_ready = 1'b1; repeat (7) tick();
        chk("bp_count", 64'(got.size()), 64'(8));
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("bp_word%0d", k), 64'(got[k]), 64'(plain[k]));

        // Back-to-back blocks with in_valid held high
        shr[0] = CT; shr[1] = '0; got.delete();
        in_valid = 1'b1; out_ready = 1'b1; caps = 0; cap2_c = -1;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (cap_flag) begin
                caps++;
                if (caps == 1) rand_shares();
                else begin in_valid = 1'b0; cap2_c = c; end
            end
        end
        chk("b2b_caps", 64'(caps), 64'(2));
        chk("b2b_cap2_cycle", 64'(cap2_c), 64'(8));
        chk("b2b_words", 64'(got.size()), 64'(16));

        // Reset after word 3 accepted, then a fresh block
        shr[0] = CT; shr[1] = '0;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; repeat (4) tick();
        do_reset();
        rand_shares(); got.delete(); out_ready = 1'b1;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; repeat (9) tick();
        chk("post_rst_count", 64'(got.size()), 64'(8));

        // d=3 block
        dsel = 1; rand_shares(); got.delete();
        in_valid = 1'b1; out_ready = 1'b1; tick();
        in_valid = 1'b0; repeat (13) tick();
        chk("d3_count", 64'(got.size()), 64'(12));

        // Randomized traffic on both widths
        for (int sel = 0; sel < 2; sel++) begin
            dsel = sel;
            for (int c = 0; c < 300; c++) begin
                if (!in_valid && ($urandom_range(3) == 0)) begin
                    in_valid = 1'b1;
                    rand_shares();
                end
                out_ready = ($urandom_range(9) < 7);
                tick();
                if (cap_flag) in_valid = 1'b0;
            end
            in_valid = 1'b0; out_ready = 1'b1;
            repeat (14) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msk_ciphertext_out_serializer.md
# msk_ciphertext_out_serializer

Receiver for the masked core's ciphertext output handshake (`cipher_valid` / `out_ready` / `sh_ciphertext`). It captures one 128-bit shared ciphertext in share-bus encoding and de-interleaves it. It then streams the result as 32-bit words, share by share, over a valid/ready interface toward a bus or FIFO. It sits directly behind `MSKaes_32bits_core` and provides the core's back-pressure.

## Interface
- `d`, default 2: number of shares (d ≥ 2).
- `SW`, default `(d>1)?$clog2(d):1`: width of the share index port. Derived; do not override.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  from the core's `cipher_valid`.
- `in_ready`  out  1  to the core's `out_ready`.
- `sh_data_in`  in  128*d  shared ciphertext, share-bus encoding: bit i of share s is at index i*d+s.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  32  current word.
- `out_share`  out  SW  share index of the current word.
- `out_last`  out  1  high on the final word of the block (word 4d-1).
- `busy`  out  1  a block is held (state SEND).

## Operation
- Registers:
  - `buf`: 128*d bits.
  - `cnt`: word counter, width `$clog2(4*d)`.
  - `state`: IDLE or SEND.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`: `buf` <= `sh_data_in`, `cnt` <= 0, go to SEND.
- SEND:
  - `out_valid`=1.
  - Word k=`cnt` is defined by s=k/4 and w=k%4.
  - `out_data[b]` = `buf[(32w+b)*d+s]`, for b=0..31.
  - `out_share`=s.
  - `out_last`=(k==4d-1).
- Word order: share 0 words 0..3, then share 1 words 0..3, and so on. Word 0 of a share holds state bytes 0..3, with byte 0 in bits 7:0.
- On `out_valid & out_ready`:
  - If not last: `cnt` <= `cnt`+1.
  - If last and `in_valid`: reload `buf`, `cnt` <= 0, stay in SEND.
  - If last and not `in_valid`: go to IDLE.
- `in_ready` = (state==IDLE) | (state==SEND & `out_last` & `out_ready`). This combinational path from `out_ready` is intended and gives zero-bubble back-to-back blocks.
- `out_data`, `out_share` and `out_last` are decoded from `buf`/`cnt`. They are stable while `out_valid & !out_ready`.
- The block performs no recombination. Shares never meet in combinational logic; each output bit selects exactly one `buf` bit.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state <= IDLE, `cnt` <= 0, `buf` <= 0.
  - Effective next cycle: `out_valid`=0, `out_last`=0, `out_share`=0, `out_data`=0, `busy`=0.
  - `in_ready` is forced to 0 while `rst_n`=0.
- Latency: a capture at edge n gives `out_valid`=1 in cycle n+1 with word 0.
- Throughput: with `out_ready`=1, one word per cycle, 4d cycles per block, and no idle cycles between consecutive blocks.
- Reset mid-block discards the held block; no partial word is emitted afterwards.
- `in_valid` high while in SEND and not on the last accepted word: `in_ready`=0 and the core holds its output.
- `cnt` never exceeds 4d-1; there is no wrap except via last-word reload/return.

## Test plan
- d=2, `out_ready`=1:
  - Stimulus: share0 = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469, share1 = 0.
  - Required words: d8e0c469, 30047b6a, 80b7cdd8, 5ac5b470, then 4×00000000.
  - `out_share` is 0,0,0,0,1,1,1,1; `out_last` only on word 7; first `out_valid` one cycle after capture.
- Masked d=2:
  - Stimulus: share1 = all-ones, share0 = the ciphertext above XOR all-ones.
  - Required: word k XOR word k+4 equals the corresponding plain word above, for k=0..3.
- Back-pressure: drop `out_ready` for 5 cycles while word 2 is presented. Required: `out_data`=80b7cdd8 stable throughout, `in_ready`=0, all 8 words delivered once, in order.
- Back-to-back: `in_valid` held high with two distinct blocks, `out_ready`=1. Required: `in_ready` pulses exactly in the cycle word 7 is accepted; 16 consecutive valid words with no gap.
- Reset mid-block: assert `rst_n`=0 for one edge after word 3 is accepted. Required: `out_valid`=0 and `busy`=0 next cycle; `in_ready`=1 once `rst_n`=1; the next block starts at word 0, share 0.
- d=3: 12 words per block, `out_share` sequence 0×4, 1×4, 2×4, `out_last` on word 11, and per-share words match the de-interleaved input.
